// File: rtl/csa_tree_pipe.sv
// Pipelined carry-save (3:2) adder tree with a final carry-propagate adder,
// valid/ready flow control and an optional multi-beat accumulator.
module csa_tree_pipe #(
  parameter int DATA_W  = 8,
  parameter int DATA_N  = 9,
  parameter int SIGNED  = 0,
  parameter int ACC_EN  = 0,
  parameter int ACC_EXT = 8,
  localparam int SUM_W  = DATA_W + $clog2(DATA_N),
  localparam int O_W    = SUM_W + ((ACC_EN != 0) ? ACC_EXT : 0)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [DATA_N*DATA_W-1:0] i_data,
  input  logic                     i_last,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [O_W-1:0]           o_data
);

  // Row count entering CSA level lvl: each full triple becomes two rows.
  function automatic int rows_at(input int lvl);
    int r;
    r = DATA_N;
    for (int l = 0; l < lvl; l++) r = 2 * (r / 3) + r % 3;
    return r;
  endfunction

  function automatic int csa_levels();
    for (int l = 0; l < 64; l++) begin
      if (rows_at(l) <= 2) return l;
    end
    return 64;
  endfunction

  localparam int CSA_ST = csa_levels();

  logic             en;
  logic [SUM_W-1:0] ext [0:DATA_N-1];

  assign en      = !o_valid || o_ready;
  assign i_ready = en;

  genvar gi;
  for (gi = 0; gi < DATA_N; gi++) begin : g_ext
    assign ext[gi] = {{(SUM_W - DATA_W){(SIGNED != 0) & i_data[gi*DATA_W + DATA_W - 1]}},
                      i_data[gi*DATA_W +: DATA_W]};
  end

  for (gi = 0; gi < CSA_ST; gi++) begin : g_lvl
    localparam int RIN  = rows_at(gi);
    localparam int NGRP = RIN / 3;
    localparam int ROUT = rows_at(gi + 1);

    logic [SUM_W-1:0] src [0:RIN-1];
    logic [SUM_W-1:0] nxt [0:ROUT-1];
    logic [SUM_W-1:0] row [0:ROUT-1];
    logic             src_valid;
    logic             src_last;
    logic             valid;
    logic             last;

    if (gi == 0) begin : g_src
      assign src       = ext;
      assign src_valid = i_valid;
      assign src_last  = i_last;
    end else begin : g_src
      assign src       = g_lvl[gi-1].row;
      assign src_valid = g_lvl[gi-1].valid;
      assign src_last  = g_lvl[gi-1].last;
    end

    // Triples compress to sum/carry; leftover rows ride along unchanged.
    always_comb begin
      for (int j = 0; j < ROUT; j++) nxt[j] = '0;
      for (int j = 0; j < NGRP; j++) begin
        nxt[2*j]     = src[3*j] ^ src[3*j+1] ^ src[3*j+2];
        nxt[2*j + 1] = ((src[3*j] & src[3*j+1]) | (src[3*j] & src[3*j+2]) |
                        (src[3*j+1] & src[3*j+2])) << 1;
      end
      for (int j = 0; j < RIN - 3*NGRP; j++) nxt[2*NGRP + j] = src[3*NGRP + j];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid <= 1'b0;
        last  <= 1'b0;
        for (int j = 0; j < ROUT; j++) row[j] <= '0;
      end else if (en) begin
        valid <= src_valid;
        last  <= src_last;
        row   <= nxt;
      end
    end
  end

  logic [SUM_W-1:0] top_a;
  logic [SUM_W-1:0] top_b;
  logic             top_valid;
  logic             top_last;

  if (CSA_ST > 0) begin : g_top
    assign top_a     = g_lvl[CSA_ST-1].row[0];
    assign top_b     = g_lvl[CSA_ST-1].row[1];
    assign top_valid = g_lvl[CSA_ST-1].valid;
    assign top_last  = g_lvl[CSA_ST-1].last;
  end else begin : g_top
    assign top_a     = ext[0];
    assign top_b     = ext[1];
    assign top_valid = i_valid;
    assign top_last  = i_last;
  end

  logic [SUM_W-1:0] cpa_sum;
  logic [O_W-1:0]   sum_ext;
  logic [O_W-1:0]   acc;
  logic [O_W-1:0]   total;

  assign cpa_sum = top_a + top_b;

  always_comb begin
    sum_ext            = {O_W{(SIGNED != 0) & cpa_sum[SUM_W-1]}};
    sum_ext[SUM_W-1:0] = cpa_sum;
  end

  assign total = acc + sum_ext;

  // Without accumulation every beat closes its own group, so acc stays 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      acc     <= '0;
    end else if (en) begin
      if (top_valid) begin
        if (ACC_EN == 0 || top_last) begin
          o_data  <= total;
          o_valid <= 1'b1;
          acc     <= '0;
        end else begin
          acc     <= total;
          o_valid <= 1'b0;
        end
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Scenario bench for csa_tree_pipe: several parameterisations driven from shared
// handshake lines, with a queue scoreboard on the 8-bit, 9-operand instance.
module tb_csa_tree_pipe;

  logic clk;
  logic rst_n;
  logic i_valid;
  logic i_last;
  logic o_ready;
  logic [26:0] d3;
  logic [71:0] d8;
  logic [15:0] d2;

  logic a_ir, a_ov; logic [6:0]  a_od;
  logic s_ir, s_ov; logic [6:0]  s_od;
  logic w_ir, w_ov; logic [11:0] w_od;
  logic c_ir, c_ov; logic [19:0] c_od;
  logic t_ir, t_ov; logic [8:0]  t_od;

  int n_checks = 0;
  int n_fail   = 0;
  int push_cnt = 0;
  int got_cnt  = 0;
  logic [11:0] exp_q [$];

  csa_tree_pipe #(.DATA_W(3), .DATA_N(9), .SIGNED(0)) u_a (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(a_ir), .i_data(d3),
    .i_last(i_last), .o_valid(a_ov), .o_ready(o_ready), .o_data(a_od));
  csa_tree_pipe #(.DATA_W(3), .DATA_N(9), .SIGNED(1)) u_s (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(s_ir), .i_data(d3),
    .i_last(i_last), .o_valid(s_ov), .o_ready(o_ready), .o_data(s_od));
  csa_tree_pipe #(.DATA_W(8), .DATA_N(9)) u_w (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(w_ir), .i_data(d8),
    .i_last(i_last), .o_valid(w_ov), .o_ready(o_ready), .o_data(w_od));
  csa_tree_pipe #(.DATA_W(8), .DATA_N(9), .ACC_EN(1), .ACC_EXT(8)) u_acc (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(c_ir), .i_data(d8),
    .i_last(i_last), .o_valid(c_ov), .o_ready(o_ready), .o_data(c_od));
  csa_tree_pipe #(.DATA_W(8), .DATA_N(2)) u_2 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(t_ir), .i_data(d2),
    .i_last(i_last), .o_valid(t_ov), .o_ready(o_ready), .o_data(t_od));

  always #5 clk = ~clk;

  function automatic logic [11:0] sum9(input logic [71:0] d);
    logic [11:0] s;
    s = '0;
    for (int k = 0; k < 9; k++) s = s + {4'd0, d[k*8 +: 8]};
    return s;
  endfunction

  function automatic logic [71:0] rand72();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[71:0];
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0; i_valid = 0; i_last = 0; o_ready = 1;
    @(negedge clk);
    rst_n = 1;
    exp_q.delete();
    push_cnt = 0;
    got_cnt  = 0;
    @(negedge clk);
  endtask

  // One cycle on u_w: drive, push accepted beats, pop and compare consumed results.
  task automatic step_w(input logic v, input logic [71:0] d, input logic r, output logic ir);
    logic [11:0] e;
    i_valid = v; d8 = d; o_ready = r;
    #1;
    ir = w_ir;
    if (v && w_ir) begin
      exp_q.push_back(sum9(d));
      push_cnt++;
    end
    if (w_ov && r) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL w_unexpected: got o_data=%0d, required no output", w_od);
      end else begin
        e = exp_q.pop_front();
        got_cnt++;
        if (w_od !== e) begin
          n_fail++;
          $display("FAIL w_result: got %0d, required %0d", w_od, e);
        end else $display("w result %0d ok", w_od);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain_w(input string name);
    logic ir;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) step_w(1'b0, 72'd0, 1'b1, ir);
    n_checks++;
    if (exp_q.size() != 0 || got_cnt != push_cnt) begin
      n_fail++;
      $display("FAIL %s_count: got %0d results, required %0d", name, got_cnt, push_cnt);
    end else $display("%s: %0d results received", name, got_cnt);
  endtask

  task automatic test_reset();
    rst_n = 0; i_valid = 0; i_last = 0; o_ready = 1; d3 = '0; d8 = '0; d2 = '0;
    #12;
    n_checks++;
    if ({a_ov, s_ov, w_ov, c_ov, t_ov} !== 5'b0 || w_od !== 12'd0 || c_od !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_out: got valids=%b w=%0d acc=%0d, required 0", {a_ov, s_ov, w_ov, c_ov, t_ov}, w_od, c_od);
    end else $display("reset: outputs cleared");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({a_ir, s_ir, w_ir, c_ir, t_ir} !== 5'b11111) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, required 11111", {a_ir, s_ir, w_ir, c_ir, t_ir});
    end else $display("reset: i_ready high after release");
  endtask

  task automatic test_latency_unsigned();
    int lat; logic [6:0] got;
    apply_reset();
    i_valid = 1; d3 = {9{3'd7}};
    @(negedge clk);
    i_valid = 0;
    lat = 0; got = '0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if (a_ov) begin lat = c; got = a_od; end
      else @(negedge clk);
    end
    n_checks++;
    if (lat !== 5 || got !== 7'd63) begin
      n_fail++;
      $display("FAIL unsigned_sum: got latency %0d data %0d, required 5 and 63", lat, got);
    end else $display("unsigned: latency %0d data %0d", lat, got);
  endtask

  task automatic test_signed();
    int lat; logic [6:0] got; logic [6:0] req;
    req = 7'h5C;
    apply_reset();
    i_valid = 1; d3 = {9{3'b100}};
    @(negedge clk);
    i_valid = 0;
    lat = 0; got = '0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if (s_ov) begin lat = c; got = s_od; end
      else @(negedge clk);
    end
    n_checks++;
    if (lat !== 5 || got !== req) begin
      n_fail++;
      $display("FAIL signed_sum: got latency %0d data %0d, required 5 and %0d (-36)", lat, got, req);
    end else $display("signed: latency %0d data %0d (-36)", lat, got);
  endtask

  task automatic test_back_to_back();
    int k; logic ir; logic r;
    apply_reset();
    k = 1;
    for (int c = 0; c < 100 && k <= 20; c++) begin
      r = !(c >= 8 && c < 11);
      step_w(1'b1, {9{k[7:0]}}, r, ir);
      if (!r) begin
        n_checks++;
        if (ir !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_ready: cycle %0d got i_ready=%b, required 0", c, ir);
        end else $display("stall cycle %0d: i_ready low", c);
      end
      if (ir) k++;
    end
    i_valid = 0;
    drain_w("back_to_back");
  endtask

  task automatic test_accumulate();
    logic [19:0] req [0:1];
    logic [7:0]  beat [0:3];
    int n;
    req[0] = 20'd60; req[1] = 20'd5;
    beat[0] = 8'd10; beat[1] = 8'd20; beat[2] = 8'd30; beat[3] = 8'd5;
    apply_reset();
    n = 0;
    for (int b = 0; b < 4; b++) begin
      i_valid = 1; d8 = {64'd0, beat[b]}; i_last = (b >= 2);
      @(negedge clk);
    end
    i_valid = 0; i_last = 0;
    for (int c = 0; c < 30; c++) begin
      if (c_ov) begin
        n_checks++;
        if (n > 1) begin
          n_fail++;
          $display("FAIL acc_extra: got extra result %0d, required none", c_od);
        end else if (c_od !== req[n]) begin
          n_fail++;
          $display("FAIL acc_group%0d: got %0d, required %0d", n, c_od, req[n]);
        end else $display("acc group %0d: %0d", n, c_od);
        n++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (n !== 2) begin
      n_fail++;
      $display("FAIL acc_count: got %0d results, required 2", n);
    end
  endtask

  task automatic test_reset_midstream();
    logic ir; int seen;
    apply_reset();
    for (int c = 0; c < 8; c++) step_w(1'b1, rand72(), 1'b0, ir);
    rst_n = 0; i_valid = 0;
    #1;
    n_checks++;
    if (w_ov !== 1'b0 || w_od !== 12'd0) begin
      n_fail++;
      $display("FAIL midreset_out: got valid=%b data=%0d, required 0", w_ov, w_od);
    end else $display("mid-stream reset: output cleared");
    exp_q.delete(); push_cnt = 0; got_cnt = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (w_ov) seen++;
      step_w(1'b0, 72'd0, 1'b1, ir);
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midreset_stale: got %0d stale results, required 0", seen);
    end
    step_w(1'b1, rand72(), 1'b1, ir);
    i_valid = 0;
    drain_w("after_reset");
  endtask

  task automatic test_two_operand();
    int lat; logic [8:0] got;
    apply_reset();
    i_valid = 1; d2 = {8'd255, 8'd255};
    @(negedge clk);
    i_valid = 0;
    lat = 0; got = '0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if (t_ov) begin lat = c; got = t_od; end
      else @(negedge clk);
    end
    n_checks++;
    if (lat !== 1 || got !== 9'd510) begin
      n_fail++;
      $display("FAIL two_operand: got latency %0d data %0d, required 1 and 510", lat, got);
    end else $display("two operand: latency %0d data %0d", lat, got);
  endtask

  task automatic test_random();
    logic ir;
    apply_reset();
    for (int c = 0; c < 400; c++)
      step_w(1'($urandom_range(0, 1)), rand72(), ($urandom_range(0, 3) != 0), ir);
    i_valid = 0;
    drain_w("random");
  endtask

  initial begin
    clk = 0;
    test_reset();
    test_latency_unsigned();
    test_signed();
    test_back_to_back();
    test_accumulate();
    test_reset_midstream();
    test_two_operand();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
